// File: rtl/score_tracker_bcd_pkg.sv
// -----------------------------------------------------------------------------
// score_tracker_bcd_pkg
//   Shared definitions for the Snake score tracker: game state encoding and
//   the width of one BCD digit.
// -----------------------------------------------------------------------------
package score_tracker_bcd_pkg;

    // Width of one packed BCD digit (one 7-seg nibble).
    localparam int DIGIT_W = 4;

    // Largest supported digit count; the score range is 0 .. 10^NDIG-1.
    localparam int MAX_NDIG = 6;

    // Game state as seen on the o_state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

endpackage

// File: rtl/score_tracker_bcd_if.sv
// -----------------------------------------------------------------------------
// score_tracker_bcd_if
//   Connects the game FSM (master) to the score tracker (slave) and carries
//   the BCD displays back out to the hex decoders.
//   master : drives i_start, i_increment, i_game_over, i_clear_high
//   slave  : drives o_cur_bcd, o_high_bcd, o_new_high, o_saturated, o_state
// -----------------------------------------------------------------------------
interface score_tracker_bcd_if
    import score_tracker_bcd_pkg::*;
#(
    parameter int NDIG = 3
);

    logic                    i_start;       // level, rising edge starts a game
    logic                    i_increment;   // level, rising edge adds STEP
    logic                    i_game_over;   // level, rising edge ends the game
    logic                    i_clear_high;  // level, clears high score in IDLE/OVER
    logic [DIGIT_W*NDIG-1:0] o_cur_bcd;     // current score, digit 0 = ones
    logic [DIGIT_W*NDIG-1:0] o_high_bcd;    // best score since reset or clear
    logic                    o_new_high;    // last game_over raised the high score
    logic                    o_saturated;   // current score is all 9s
    state_t                  o_state;       // IDLE / PLAY / OVER

    modport master (
        output i_start, i_increment, i_game_over, i_clear_high,
        input  o_cur_bcd, o_high_bcd, o_new_high, o_saturated, o_state
    );

    modport slave (
        input  i_start, i_increment, i_game_over, i_clear_high,
        output o_cur_bcd, o_high_bcd, o_new_high, o_saturated, o_state
    );

endinterface

// File: rtl/score_tracker_bcd_digit_add.sv
// -----------------------------------------------------------------------------
// score_tracker_bcd_digit_add
//   One stage of a ripple BCD adder: digit + addend + carry_in.
//   Ports:
//     i_digit   in  4  current BCD digit (0..9)
//     i_addend  in  4  BCD addend (0..9)
//     i_carry   in  1  carry from the next lower digit
//     o_digit   out 4  resulting BCD digit (0..9)
//     o_carry   out 1  carry into the next higher digit
// -----------------------------------------------------------------------------
module score_tracker_bcd_digit_add
    import score_tracker_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic [DIGIT_W-1:0] i_addend,
    input  logic               i_carry,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_carry
);

    // Raw binary sum fits in 5 bits: at most 9 + 9 + 1 = 19.
    logic [DIGIT_W:0] w_raw;
    logic [DIGIT_W:0] w_wrapped;
    logic             w_wrap;

    assign w_raw     = {1'b0, i_digit} + {1'b0, i_addend} + {{DIGIT_W{1'b0}}, i_carry};
    assign w_wrap    = (w_raw > 5'd9);
    assign w_wrapped = w_raw - 5'd10;

    assign o_carry = w_wrap;
    assign o_digit = w_wrap ? w_wrapped[DIGIT_W-1:0] : w_raw[DIGIT_W-1:0];

endmodule

// File: rtl/score_tracker_bcd.sv
// -----------------------------------------------------------------------------
// score_tracker_bcd
//   Snake score and high-score tracker. Counts the current score in packed
//   BCD, saturating at all 9s, and keeps the best score across games.
//   Parameters:
//     NDIG  number of BCD digits (1..6)
//     STEP  points per accepted increment (1..9)
//   Ports:
//     clk   in  system clock
//     rst   in  asynchronous, active-low reset
//     bus   slave side of score_tracker_bcd_if (see interface for signals)
// -----------------------------------------------------------------------------
module score_tracker_bcd
    import score_tracker_bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    score_tracker_bcd_if.slave bus
);

    localparam int              W         = DIGIT_W * NDIG;
    localparam logic [W-1:0]    ALL_NINES = {NDIG{4'h9}};
    localparam logic [DIGIT_W-1:0] STEP_D = DIGIT_W'(STEP);

    // Edge-detect history, one flop per level input.
    logic         r_start_q;
    logic         r_inc_q;
    logic         r_go_q;

    state_t       r_state;
    logic [W-1:0] r_cur;
    logic [W-1:0] r_high;
    logic         r_new_high;

    logic         w_rise_start;
    logic         w_rise_inc;
    logic         w_rise_go;
    logic [W-1:0] w_sum;
    logic [NDIG:0] w_carry;
    logic [W-1:0] w_cur_inc;
    logic         w_cur_gt_high;

    assign w_rise_start = bus.i_start     & ~r_start_q;
    assign w_rise_inc   = bus.i_increment & ~r_inc_q;
    assign w_rise_go    = bus.i_game_over & ~r_go_q;

    // Ripple BCD add: STEP enters digit 0, higher digits only take the carry.
    assign w_carry[0] = 1'b0;

    for (genvar g = 0; g < NDIG; g++) begin : g_add
        localparam logic [DIGIT_W-1:0] ADDEND = (g == 0) ? STEP_D : '0;

        score_tracker_bcd_digit_add u_digit_add (
            .i_digit  (r_cur[DIGIT_W*g +: DIGIT_W]),
            .i_addend (ADDEND),
            .i_carry  (w_carry[g]),
            .o_digit  (w_sum[DIGIT_W*g +: DIGIT_W]),
            .o_carry  (w_carry[g+1])
        );
    end

    // A carry out of the top digit would wrap the score; pin it at all 9s.
    assign w_cur_inc = w_carry[NDIG] ? ALL_NINES : w_sum;

    // MSD-first digit compare: cur > high is decided by the first digit pair
    // that differs, scanning down from the top.
    logic [NDIG:0] w_gt;
    logic [NDIG:1] w_eq;

    assign w_gt[NDIG] = 1'b0;
    assign w_eq[NDIG] = 1'b1;

    for (genvar g = NDIG - 1; g >= 0; g--) begin : g_cmp
        logic [DIGIT_W-1:0] w_cd;
        logic [DIGIT_W-1:0] w_hd;

        assign w_cd    = r_cur [DIGIT_W*g +: DIGIT_W];
        assign w_hd    = r_high[DIGIT_W*g +: DIGIT_W];
        assign w_gt[g] = w_gt[g+1] | (w_eq[g+1] & (w_cd > w_hd));

        if (g > 0) begin : g_eq
            assign w_eq[g] = w_eq[g+1] & (w_cd == w_hd);
        end
    end

    assign w_cur_gt_high = w_gt[0];

    // NOTE: clocked state uses non-blocking assignments so every flop updates
    // from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q  <= 1'b0;
            r_inc_q    <= 1'b0;
            r_go_q     <= 1'b0;
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_start_q <= bus.i_start;
            r_inc_q   <= bus.i_increment;
            r_go_q    <= bus.i_game_over;

            case (r_state)
                ST_PLAY: begin
                    // start beats game_over beats increment; clear_high is
                    // deliberately ignored while a game is running.
                    if (w_rise_start) begin
                        r_cur      <= '0;
                        r_new_high <= 1'b0;
                    end else if (w_rise_go) begin
                        r_state <= ST_OVER;
                        if (w_cur_gt_high) begin
                            r_high     <= r_cur;
                            r_new_high <= 1'b1;
                        end else begin
                            r_new_high <= 1'b0;
                        end
                    end else if (w_rise_inc) begin
                        r_cur <= w_cur_inc;
                    end
                end

                default: begin  // ST_IDLE, ST_OVER
                    if (bus.i_clear_high) begin
                        r_high     <= '0;
                        r_new_high <= 1'b0;
                    end
                    if (w_rise_start) begin
                        r_state    <= ST_PLAY;
                        r_cur      <= '0;
                        r_new_high <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.o_cur_bcd   = r_cur;
    assign bus.o_high_bcd  = r_high;
    assign bus.o_new_high  = r_new_high;
    assign bus.o_state     = r_state;
    assign bus.o_saturated = (r_cur == ALL_NINES);

endmodule
